// File: rtl/alu_seq.sv
// alu_seq: registered ALU with single-cycle ops and an iterative
// shift-add multiplier that keeps the ALU busy for WIDTH cycles.
module alu_seq #(
  parameter int WIDTH = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic [3:0]       i_s,
  output logic [WIDTH-1:0] o_o,
  output logic [WIDTH-1:0] o_hi,
  output logic             o_cout,
  output logic             o_oflow,
  output logic             o_ntive,
  output logic             o_zero,
  output logic             o_busy,
  output logic             o_done
);

  localparam int SW = $clog2(WIDTH);
  localparam int M  = WIDTH - 1;
  localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t           r_state;
  logic [SW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_pa;
  logic [WIDTH-1:0] r_ph;
  logic [WIDTH-1:0] r_pl;
  logic [WIDTH-1:0] r_o;
  logic [WIDTH-1:0] r_hi;
  logic             r_cout;
  logic             r_oflow;
  logic             r_ntive;
  logic             r_zero;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [SW-1:0]    w_sh;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_nh;
  logic [WIDTH-1:0] w_nl;

  assign w_sh  = i_b[SW-1:0];
  assign w_add = {1'b0, i_a} + {1'b0, i_b}
               + {{WIDTH{1'b0}}, i_cin};
  assign w_sub = {1'b0, i_a} - {1'b0, i_b};

  // one shift-add step: add multiplicand if the low multiplier bit
  // is set, then shift {carry,hi,lo} right by one
  assign w_sum = {1'b0, r_ph}
               + (r_pl[0] ? {1'b0, r_pa} : '0);
  assign w_nh  = w_sum[WIDTH:1];
  assign w_nl  = {w_sum[0], r_pl[WIDTH-1:1]};

  // single-cycle result and carry/overflow from the live inputs
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (i_s)
      4'd0: begin
        w_res = w_add[M:0];
        w_c   = w_add[WIDTH];
        w_v   = (i_a[M] == i_b[M]) && (w_add[M] != i_a[M]);
      end
      4'd1: begin
        w_res = w_sub[M:0];
        w_c   = ~w_sub[WIDTH];
        w_v   = (i_a[M] != i_b[M]) && (w_sub[M] != i_a[M]);
      end
      4'd2:  w_res = i_a & i_b;
      4'd3:  w_res = i_a | i_b;
      4'd4:  w_res = i_a ^ i_b;
      4'd5:  w_res = ~i_a;
      4'd6:  w_res = i_a << w_sh;
      4'd7:  w_res = i_a >> w_sh;
      4'd8:  w_res = $signed(i_a) >>> w_sh;
      4'd10: w_res = i_b;
      4'd11: w_res = {{M{1'b0}}, $signed(i_a) < $signed(i_b)};
      default: w_res = '0;
    endcase
  end

  // control FSM plus all registered results and flags
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pa    <= '0;
      r_ph    <= '0;
      r_pl    <= '0;
      r_o     <= '0;
      r_hi    <= '0;
      r_cout  <= 1'b0;
      r_oflow <= 1'b0;
      r_ntive <= 1'b0;
      r_zero  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            if (i_s == 4'd9) begin
              r_state <= MUL;
              r_busy  <= 1'b1;
              r_cnt   <= '0;
              r_pa    <= i_a;
              r_ph    <= '0;
              r_pl    <= i_b;
            end else begin
              r_o     <= w_res;
              r_hi    <= '0;
              r_cout  <= w_c;
              r_oflow <= w_v;
              r_ntive <= w_res[M];
              r_zero  <= (w_res == '0);
              r_done  <= 1'b1;
            end
          end
        end
        MUL: begin
          r_ph  <= w_nh;
          r_pl  <= w_nl;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_o     <= w_nl;
            r_hi    <= w_nh;
            r_cout  <= 1'b0;
            r_oflow <= 1'b0;
            r_ntive <= w_nh[M];
            r_zero  <= ({w_nh, w_nl} == '0);
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_o     = r_o;
  assign o_hi    = r_hi;
  assign o_cout  = r_cout;
  assign o_oflow = r_oflow;
  assign o_ntive = r_ntive;
  assign o_zero  = r_zero;
  assign o_busy  = r_busy;
  assign o_done  = r_done;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random checks of alu_seq at WIDTH 64 and 8
// against an arithmetic reference model.
module tb_alu_seq;

  typedef logic signed [131:0] big_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic        st64 = 0, cin64 = 0;
  logic [63:0] a64 = 0, b64 = 0;
  logic [3:0]  s64 = 0;
  logic [63:0] o64, hi64;
  logic        co64, ov64, ng64, zr64, busy64, done64;

  logic        st8 = 0, cin8 = 0;
  logic [7:0]  a8 = 0, b8 = 0;
  logic [3:0]  s8 = 0;
  logic [7:0]  o8, hi8;
  logic        co8, ov8, ng8, zr8, busy8, done8;

  alu_seq #(.WIDTH(64)) u64 (
    .i_clk(clk), .i_rst(rst), .i_start(st64),
    .i_a(a64), .i_b(b64), .i_cin(cin64), .i_s(s64),
    .o_o(o64), .o_hi(hi64), .o_cout(co64), .o_oflow(ov64),
    .o_ntive(ng64), .o_zero(zr64), .o_busy(busy64),
    .o_done(done64)
  );

  alu_seq #(.WIDTH(8)) u8 (
    .i_clk(clk), .i_rst(rst), .i_start(st8),
    .i_a(a8), .i_b(b8), .i_cin(cin8), .i_s(s8),
    .o_o(o8), .o_hi(hi8), .o_cout(co8), .o_oflow(ov8),
    .o_ntive(ng8), .o_zero(zr8), .o_busy(busy8),
    .o_done(done8)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference: plain signed/unsigned arithmetic on wide integers
  function automatic void model(
    input int w, input logic [3:0] s,
    input logic [63:0] ai, input logic [63:0] bi, input logic cin,
    output logic [63:0] o, output logic [63:0] hi,
    output logic [3:0] fl);
    big_t one, m, a, b, sa, sb, r, rh, lim, cb, bw, t;
    int sh;
    logic c, v, ng, zr;
    one = 1;
    m   = (one << w) - one;
    a   = {68'b0, ai} & m;
    b   = {68'b0, bi} & m;
    cb  = {131'b0, cin};
    bw  = w;
    lim = one << (w - 1);
    sa  = (a >= lim) ? a - (one << w) : a;
    sb  = (b >= lim) ? b - (one << w) : b;
    sh  = int'(b % bw);
    c = 0; v = 0; rh = 0; r = 0;
    case (s)
      4'd0: begin
        r = a + b + cb;
        c = (r > m);
        t = sa + sb + cb;
        v = (t >= lim) || (t < -lim);
      end
      4'd1: begin
        r = a - b;
        c = (a >= b);
        t = sa - sb;
        v = (t >= lim) || (t < -lim);
      end
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = m - a;
      4'd6:  r = a << sh;
      4'd7:  r = a >> sh;
      4'd8:  r = sa >>> sh;
      4'd9: begin
        r  = a * b;
        rh = r >> w;
      end
      4'd10: r = b;
      4'd11: r = (sa < sb) ? one : 0;
      default: r = 0;
    endcase
    o  = 64'(r & m);
    hi = 64'(rh & m);
    if (s == 4'd9) begin
      ng = hi[w-1];
      zr = (o == 0) && (hi == 0);
    end else begin
      ng = o[w-1];
      zr = (o == 0);
    end
    fl = {c, v, ng, zr};
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom % 5)
      0: return 64'h0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic go64(input logic [3:0] s, input logic [63:0] a,
                      input logic [63:0] b, input logic cin);
    logic [63:0] eo, eh;
    logic [3:0]  ef;
    model(64, s, a, b, cin, eo, eh, ef);
    @(negedge clk);
    s64 = s; a64 = a; b64 = b; cin64 = cin; st64 = 1;
    @(posedge clk);
    #1;
    st64 = 0;
    a64 = ~a; b64 = ~b; s64 = ~s;
    chk($sformatf("w64_done_s%0d", s), 64'(done64), 64'd1);
    chk($sformatf("w64_o_s%0d", s), o64, eo);
    chk($sformatf("w64_hi_s%0d", s), hi64, eh);
    chk($sformatf("w64_fl_s%0d", s),
        64'({co64, ov64, ng64, zr64}), 64'(ef));
  endtask

  task automatic go8(input logic [3:0] s, input logic [7:0] a,
                     input logic [7:0] b, input logic cin);
    logic [63:0] eo, eh;
    logic [3:0]  ef;
    model(8, s, {56'b0, a}, {56'b0, b}, cin, eo, eh, ef);
    @(negedge clk);
    s8 = s; a8 = a; b8 = b; cin8 = cin; st8 = 1;
    @(posedge clk);
    #1;
    st8 = 0;
    chk($sformatf("w8_done_s%0d", s), 64'(done8), 64'd1);
    chk($sformatf("w8_o_s%0d", s), 64'(o8), eo);
    chk($sformatf("w8_hi_s%0d", s), 64'(hi8), eh);
    chk($sformatf("w8_fl_s%0d", s),
        64'({co8, ov8, ng8, zr8}), 64'(ef));
  endtask

  task automatic mul8(input logic [7:0] a, input logic [7:0] b,
                      input bit poke);
    logic [63:0] eo, eh;
    logic [3:0]  ef;
    int n, nd;
    model(8, 4'd9, {56'b0, a}, {56'b0, b}, 1'b0, eo, eh, ef);
    @(negedge clk);
    s8 = 4'd9; a8 = a; b8 = b; st8 = 1;
    @(posedge clk);
    #1;
    st8 = 0;
    a8 = 8'($urandom); b8 = 8'($urandom); s8 = 4'd0;
    n = 0; nd = 0;
    while (busy8 && n < 40) begin
      st8 = poke && (n == 2);
      @(posedge clk);
      #1;
      n++;
      if (done8) nd++;
    end
    st8 = 0;
    chk("mul_busy_cycles", 64'(n), 64'd8);
    chk("mul_done_count", 64'(nd), 64'd1);
    chk("mul_o", 64'(o8), eo);
    chk("mul_hi", 64'(hi8), eh);
    chk("mul_fl", 64'({co8, ov8, ng8, zr8}), 64'(ef));
    @(posedge clk);
    #1;
    chk("mul_done_after", 64'({done8, busy8}), 64'd0);
  endtask

  initial begin
    int nd;
    logic [3:0] s;

    #12;
    chk("rst_o", o64, 64'd0);
    chk("rst_hi", hi64, 64'd0);
    chk("rst_flags", 64'({co64, ov64, ng64, zr64, busy64, done64}), 64'd0);
    chk("rst8_all", 64'({o8, hi8, co8, ov8, ng8, zr8, busy8, done8}), 64'd0);
    @(negedge clk);
    rst = 0;

    go64(4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    chk("add1_o", o64, 64'h7FFF_FFFF_FFFF_FFFE);
    chk("add1_fl", 64'({co64, ov64, ng64, zr64}), 64'b1000);
    go64(4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    chk("add2_o", o64, 64'h8000_0000_0000_0000);
    chk("add2_fl", 64'({co64, ov64, ng64}), 64'b011);

    go64(4'd1, 64'd5, 64'd5, 1'b0);
    chk("b2b_sub_o", o64, 64'd0);
    chk("b2b_sub_zc", 64'({zr64, co64}), 64'b11);
    go64(4'd4, 64'hF0, 64'h0F, 1'b0);
    chk("b2b_xor_o", o64, 64'hFF);
    chk("b2b_xor_z", 64'(zr64), 64'd0);
    @(posedge clk);
    #1;
    chk("done_fall", 64'(done64), 64'd0);
    chk("hold_o", o64, 64'hFF);

    mul8(8'hFF, 8'hFF, 1'b1);
    chk("mul_ff_hi", 64'(hi8), 64'hFE);
    chk("mul_ff_o", 64'(o8), 64'h01);
    chk("mul_ff_ng", 64'(ng8), 64'd1);

    go8(4'd8, 8'h80, 8'd3, 1'b0);
    chk("sra_o", 64'(o8), 64'hF0);
    chk("sra_ng", 64'(ng8), 64'd1);
    go8(4'd6, 8'h01, 8'd9, 1'b0);
    chk("shl9_o", 64'(o8), 64'h02);

    @(negedge clk);
    s8 = 4'd9; a8 = 8'h12; b8 = 8'h34; st8 = 1;
    @(posedge clk);
    #1;
    st8 = 0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1;
    #1;
    chk("arst_o8", 64'({o8, hi8}), 64'd0);
    chk("arst_fl8", 64'({co8, ov8, ng8, zr8, busy8, done8}), 64'd0);
    chk("arst_o64", o64, 64'd0);
    @(negedge clk);
    rst = 0;
    nd = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done8) nd++;
    end
    chk("arst_no_done", 64'(nd), 64'd0);
    go8(4'd0, 8'd1, 8'd1, 1'b0);
    chk("post_rst_add", 64'(o8), 64'd2);

    for (int i = 0; i < 150; i++) begin
      s = 4'($urandom_range(0, 15));
      if (s == 4'd9) s = 4'd11;
      go64(s, pick(), pick(), 1'($urandom));
    end
    for (int i = 0; i < 120; i++) begin
      s = 4'($urandom_range(0, 15));
      if (s == 4'd9)
        mul8(8'($urandom), 8'($urandom), 1'($urandom));
      else
        go8(s, 8'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
